// File: rtl/seg_counter_mux.sv
// seg_counter_mux: BCD up/down counter with a prescaled count tick and a
// time-multiplexed 7-segment driver (active-low anodes, active-high segments).
// The count ripples through all digits in a single cycle. The display path
// registers anode and segment values from the current digit index, so the
// segments trail count_bcd by one cycle.
module seg_counter_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000000,
    parameter int SCAN_DIV   = 6250000,
    parameter int BLANK_LZ   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clr,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    carry
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam bit BLANK_EN = (BLANK_LZ != 32'sd0);

    logic [PW-1:0]           r_presc;
    logic [SW-1:0]           r_scan;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_count;
    logic                    r_carry;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;

    logic                    w_tick;
    logic [4*NUM_DIGITS-1:0] w_next_count;
    logic                    w_prop;
    logic [3:0]              w_dig;
    logic [3:0]              w_sel_dig;
    logic                    w_sel_blank;
    logic                    w_zero_above;

    // Segment pattern for one BCD digit; bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Active-low anode vector with only the selected digit driven low.
    function automatic logic [NUM_DIGITS-1:0] an_from_idx(input logic [IW-1:0] idx);
        logic [NUM_DIGITS-1:0] a;
        a = {NUM_DIGITS{1'b1}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx) begin
                a[i] = 1'b0;
            end else begin
                a[i] = 1'b1;
            end
        end
        return a;
    endfunction

    assign w_tick = en && (r_presc == PW'(TICK_DIV - 1));

    // Next count value: full ripple of increment/decrement across all digits.
    always_comb begin
        w_next_count = r_count;
        w_prop       = 1'b1;
        w_dig        = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_dig = r_count[4*i +: 4];
            if (w_prop) begin
                if (up_dn) begin
                    if (w_dig >= 4'd9) begin
                        w_next_count[4*i +: 4] = 4'd0;
                        w_prop                 = 1'b1;
                    end else begin
                        w_next_count[4*i +: 4] = w_dig + 4'd1;
                        w_prop                 = 1'b0;
                    end
                end else begin
                    if (w_dig == 4'd0) begin
                        w_next_count[4*i +: 4] = 4'd9;
                        w_prop                 = 1'b1;
                    end else begin
                        w_next_count[4*i +: 4] = w_dig - 4'd1;
                        w_prop                 = 1'b0;
                    end
                end
            end else begin
                w_next_count[4*i +: 4] = w_dig;
            end
        end
    end

    // Pick the digit under the scan index and decide leading-zero blanking.
    always_comb begin
        w_sel_dig    = 4'd0;
        w_sel_blank  = 1'b0;
        w_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above & (r_count[4*i +: 4] == 4'd0);
            if (IW'(i) == r_idx) begin
                w_sel_dig   = r_count[4*i +: 4];
                w_sel_blank = BLANK_EN && (i > 0) && w_zero_above;
            end else begin
                w_sel_blank = w_sel_blank;
            end
        end
    end

    // Count path: prescaler, BCD count and the one-cycle wrap/borrow pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= {PW{1'b0}};
            r_count <= {(4*NUM_DIGITS){1'b0}};
            r_carry <= 1'b0;
        end else if (clr) begin
            r_presc <= {PW{1'b0}};
            r_count <= {(4*NUM_DIGITS){1'b0}};
            r_carry <= 1'b0;
        end else if (en) begin
            if (w_tick) begin
                r_presc <= {PW{1'b0}};
                r_count <= w_next_count;
                r_carry <= w_prop;
            end else begin
                r_presc <= r_presc + PW'(1);
                r_carry <= 1'b0;
            end
        end else begin
            r_carry <= 1'b0;
        end
    end

    // Scan timer and digit index; runs every cycle independent of en/clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan <= {SW{1'b0}};
            r_idx  <= {IW{1'b0}};
        end else if (r_scan == SW'(SCAN_DIV - 1)) begin
            r_scan <= {SW{1'b0}};
            if (r_idx == IW'(NUM_DIGITS - 1)) begin
                r_idx <= {IW{1'b0}};
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end else begin
            r_scan <= r_scan + SW'(1);
            r_idx  <= r_idx;
        end
    end

    // Registered display drive from the current index and count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an  <= an_from_idx({IW{1'b0}});
            r_seg <= 7'b1111110;
        end else begin
            r_an  <= an_from_idx(r_idx);
            r_seg <= w_sel_blank ? 7'b0000000 : seg7_decode(w_sel_dig);
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign count_bcd = r_count;
    assign carry     = r_carry;

endmodule
